decoder_2to4: RTL and testbench



---
 rtl/decoder_2to4_pkg.sv | 21 ++
 rtl/decoder_2to4_if.sv | 22 ++
 rtl/decoder_2to4_comb.sv | 57 +++++
 rtl/decoder_2to4.sv | 29 ++
 tb/tb_decoder_2to4.sv | 140 ++++++++++++++
 5 files changed

// File: rtl/decoder_2to4_pkg.sv
// Shared names and golden decode for the 2-to-4 one-hot decoder.
// Style names select the implementation inside decoder_2to4_comb.
package decoder_2to4_pkg;

    localparam string SEL_ASSIGN      = "Assign";
    localparam string SEL_CASE        = "Case";
    localparam string SEL_FUNC_AND_IF = "Func_and_if";
    localparam string SEL_SHIFT       = "Shift";

    // Unknown index propagates as all-X rather than aliasing to a legal code.
    function automatic logic [3:0] dec2to4(input logic [1:0] a);
        case (a)
            2'd0:    return 4'b0001;
            2'd1:    return 4'b0010;
            2'd2:    return 4'b0100;
            2'd3:    return 4'b1000;
            default: return 4'bxxxx;
        endcase
    endfunction

endpackage

// File: rtl/decoder_2to4_if.sv
// Signal bundle for decoder_2to4: index in, combinational and registered one-hot out.
// Carries the en input only when DECODER_2TO4_ENABLE_EN is defined.
interface decoder_2to4_if;
    import decoder_2to4_pkg::*;

    logic [1:0] a;
`ifdef DECODER_2TO4_ENABLE_EN
    logic       en;
`endif
    logic [3:0] b;
    logic [3:0] b_q;

    // No handshake: a is sampled every cycle, b follows a combinationally, b_q one edge later.
`ifdef DECODER_2TO4_ENABLE_EN
    modport master (output a, output en, input b, input b_q);
    modport slave  (input a, input en, output b, output b_q);
`else
    modport master (output a, input b, input b_q);
    modport slave  (input a, output b, output b_q);
`endif

endinterface

// File: rtl/decoder_2to4_comb.sv
// Combinational 2-to-4 decode; SELECT picks one of four equivalent coding styles.
// Optional en gating when DECODER_2TO4_ENABLE_EN is defined.
module decoder_2to4_comb
    import decoder_2to4_pkg::*;
#(
    parameter string SELECT = SEL_FUNC_AND_IF
) (
    input  logic [1:0] a,
`ifdef DECODER_2TO4_ENABLE_EN
    input  logic       en,
`endif
    output logic [3:0] b
);

    logic [3:0] raw;

    generate
        if (SELECT == SEL_ASSIGN) begin : g_assign
            assign raw[0] = (a == 2'd0);
            assign raw[1] = (a == 2'd1);
            assign raw[2] = (a == 2'd2);
            assign raw[3] = (a == 2'd3);
        end else if (SELECT == SEL_CASE) begin : g_case
            always_comb begin
                raw = 4'bxxxx;
                case (a)
                    2'd0:    raw = 4'b0001;
                    2'd1:    raw = 4'b0010;
                    2'd2:    raw = 4'b0100;
                    2'd3:    raw = 4'b1000;
                    default: raw = 4'bxxxx;
                endcase
            end
        end else if (SELECT == SEL_FUNC_AND_IF) begin : g_func
            function automatic logic [3:0] dec_if(input logic [1:0] s);
                if (s == 2'd0)      return 4'b0001;
                else if (s == 2'd1) return 4'b0010;
                else if (s == 2'd2) return 4'b0100;
                else if (s == 2'd3) return 4'b1000;
                else                return 4'bxxxx;
            endfunction
            assign raw = dec_if(a);
        end else if (SELECT == SEL_SHIFT) begin : g_shift
            assign raw = 4'b0001 << a;
        end else begin : g_bad_select
            $error("decoder_2to4_comb: unsupported SELECT value");
            assign raw = 4'b0000;
        end
    endgenerate

`ifdef DECODER_2TO4_ENABLE_EN
    assign b = en ? raw : 4'b0000;
`else
    assign b = raw;
`endif

endmodule

// File: rtl/decoder_2to4.sv
// 2-to-4 one-hot decoder with a registered copy (b_q, 1-cycle latency, sync reset to 0000).
// Optional enable input via macro DECODER_2TO4_ENABLE_EN.
module decoder_2to4
    import decoder_2to4_pkg::*;
#(
    parameter string SELECT = SEL_FUNC_AND_IF
) (
    input  logic          clk,
    input  logic          rst,
    decoder_2to4_if.slave bus
);

    decoder_2to4_comb #(
        .SELECT (SELECT)
    ) u_comb (
        .a  (bus.a),
`ifdef DECODER_2TO4_ENABLE_EN
        .en (bus.en),
`endif
        .b  (bus.b)
    );

    // Registering the already-gated b keeps en=0 loading 0000, with rst still dominant.
    always_ff @(posedge clk) begin
        if (rst) bus.b_q <= 4'b0000;
        else     bus.b_q <= bus.b;
    end

endmodule

// File: tb/tb_decoder_2to4.sv
// Bench for decoder_2to4: all four SELECT styles run side by side against a reference model.
// Exercises en gating as well when DECODER_2TO4_ENABLE_EN is defined.
module tb_decoder_2to4;
    import decoder_2to4_pkg::*;

`ifdef DECODER_2TO4_ENABLE_EN
    localparam bit HAS_EN = 1'b1;
`else
    localparam bit HAS_EN = 1'b0;
`endif

    // clock / reset
    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    decoder_2to4_if if_func ();
    decoder_2to4_if if_asg ();
    decoder_2to4_if if_case ();
    decoder_2to4_if if_shift ();

    decoder_2to4 #(.SELECT(SEL_FUNC_AND_IF)) u_func  (.clk(clk), .rst(rst), .bus(if_func.slave));
    decoder_2to4 #(.SELECT(SEL_ASSIGN))      u_asg   (.clk(clk), .rst(rst), .bus(if_asg.slave));
    decoder_2to4 #(.SELECT(SEL_CASE))        u_case  (.clk(clk), .rst(rst), .bus(if_case.slave));
    decoder_2to4 #(.SELECT(SEL_SHIFT))       u_shift (.clk(clk), .rst(rst), .bus(if_shift.slave));

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: one-hot index as a power of two; disabled decoder outputs zero.
    function automatic logic [3:0] ref_b(input int av, input bit ev);
        if (HAS_EN && !ev) return 4'b0000;
        return 4'(2 ** av);
    endfunction

    task automatic drive(input logic [1:0] av, input logic rv, input logic ev);
        if_func.a = av; if_asg.a = av; if_case.a = av; if_shift.a = av;
        rst = rv;
`ifdef DECODER_2TO4_ENABLE_EN
        if_func.en = ev; if_asg.en = ev; if_case.en = ev; if_shift.en = ev;
`else
        if (ev) begin end
`endif
    endtask

    task automatic check_b(input string tag, input logic [3:0] exp, input bit onehot);
        check({tag, "_b_func"},  if_func.b,  exp);
        check({tag, "_b_asg"},   if_asg.b,   exp);
        check({tag, "_b_case"},  if_case.b,  exp);
        check({tag, "_b_shift"}, if_shift.b, exp);
        check({tag, "_b_golden"}, if_func.b, dec2to4(if_func.a) & {4{exp != 4'b0000}});
        if (onehot) begin
            check({tag, "_pop_asg"},   4'($countones(if_asg.b)),   4'd1);
            check({tag, "_pop_case"},  4'($countones(if_case.b)),  4'd1);
            check({tag, "_pop_shift"}, 4'($countones(if_shift.b)), 4'd1);
        end
    endtask

    // One clock: drive, check comb output, predict b_q, take the edge, check b_q.
    task automatic cycle(input string tag, input logic [1:0] av, input logic rv, input logic ev);
        logic [3:0] e;
        drive(av, rv, ev);
        #1;
        e = ref_b(int'(av), ev);
        check_b(tag, e, e != 4'b0000);
        exp_q.push_back(rv ? 4'b0000 : e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 4'b1111, 4'b0000);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_bq_func"},  if_func.b_q,  e);
            check({tag, "_bq_asg"},   if_asg.b_q,   e);
            check({tag, "_bq_case"},  if_case.b_q,  e);
            check({tag, "_bq_shift"}, if_shift.b_q, e);
        end
    endtask

    initial begin
        logic [1:0] ra;
        drive(2'd0, 1'b1, 1'b1);

        // Combinational sweep in 5 ns steps, all styles compared together.
        $display("     t  a a1 a0  b3 b2 b1 b0");
        for (int i = 0; i < 4; i++) begin
            drive(2'(i), 1'b1, 1'b1);
            #1;
            ra = if_func.a;
            $display("%6t  %0d  %b  %b   %b  %b  %b  %b", $time, ra, ra[1], ra[0],
                     if_func.b[3], if_func.b[2], if_func.b[1], if_func.b[0]);
            check_b("sweep", ref_b(i, 1'b1), 1'b1);
            #4;
        end

        @(posedge clk);
        #1;

        // Reset held 2 clocks with a=3, then release.
        cycle("rst_hold0", 2'd3, 1'b1, 1'b1);
        cycle("rst_hold1", 2'd3, 1'b1, 1'b1);
        cycle("rst_rel",   2'd3, 1'b0, 1'b1);

        // Sequence 0,3,1,2 with one cycle latency on b_q.
        cycle("seq0", 2'd0, 1'b0, 1'b1);
        cycle("seq3", 2'd3, 1'b0, 1'b1);
        cycle("seq1", 2'd1, 1'b0, 1'b1);
        cycle("seq2", 2'd2, 1'b0, 1'b1);

        // Reset mid-stream at a=2, then resume.
        cycle("mid_rst",  2'd2, 1'b1, 1'b1);
        cycle("mid_post", 2'd2, 1'b0, 1'b1);

        if (HAS_EN) begin
            cycle("en_off",   2'd1, 1'b0, 1'b0);
            cycle("en_on",    2'd1, 1'b0, 1'b1);
            cycle("en_rst",   2'd1, 1'b1, 1'b1);
            cycle("en_off_r", 2'd2, 1'b1, 1'b0);
        end

        for (int n = 0; n < 60; n++) begin
            cycle("rand", 2'($urandom_range(3)), 1'($urandom_range(7) == 0),
                  1'($urandom_range(3) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
